// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch-port, data-port and shared-MMU signals around the memory port arbiter.
// slave: the arbiter's view; master: requesters plus MMU, driven by the surrounding logic.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;

    logic        dm_req;
    logic        dm_wen;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_bsel;
    logic [31:0] dm_rdata;
    logic        dm_done;

    logic [31:0] mmu_addy;
    logic [31:0] mmu_datain;
    logic        mmu_ren;
    logic        mmu_wen;
    logic [3:0]  mmu_bsel;
    logic [31:0] mmu_dataout;
    logic        mmu_nostall;

    logic        timeout_err;

    modport slave (
        input  if_req, if_addr, dm_req, dm_wen, dm_addr, dm_wdata, dm_bsel,
               mmu_dataout, mmu_nostall,
        output if_rdata, if_done, dm_rdata, dm_done,
               mmu_addy, mmu_datain, mmu_ren, mmu_wen, mmu_bsel, timeout_err
    );

    modport master (
        output if_req, if_addr, dm_req, dm_wen, dm_addr, dm_wdata, dm_bsel,
               mmu_dataout, mmu_nostall,
        input  if_rdata, if_done, dm_rdata, dm_done,
               mmu_addy, mmu_datain, mmu_ren, mmu_wen, mmu_bsel, timeout_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose: arbitrates fetch and data ports onto one MMU; DM-first, or round-robin with MEM_ARB_ROUND_ROBIN_EN.
// Latency: grant on the request edge, done pulse 2 cycles after request at best.
// Backpressure: MMU stalls via mmu_nostall=0; watchdog aborts after TIMEOUT_CYCLES.
module mem_port_arbiter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, GRANT_IF, GRANT_DM} state_t;

    localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state, state_nxt;
    logic [31:0] addr_q, wdata_q, if_rdata_q, dm_rdata_q;
    logic [3:0]  bsel_q;
    logic        wen_q, if_done_q, dm_done_q, timeout_q;
    logic [7:0]  wd_cnt;
    logic        if_vis, dm_vis, pick_dm, finish, expire;

    // A port whose done is pulsing is still holding req; do not re-grant it.
    assign if_vis = bus.if_req && !if_done_q;
    assign dm_vis = bus.dm_req && !dm_done_q;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_dm;
    assign pick_dm = dm_vis && (!if_vis || !last_dm);
`else
    assign pick_dm = dm_vis;
`endif

    assign finish = (state != IDLE) && bus.mmu_nostall;
    assign expire = (state != IDLE) && !bus.mmu_nostall && (wd_cnt == WD_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        bus.mmu_ren = 1'b0;
        bus.mmu_wen = 1'b0;
        case (state)
            IDLE: begin
                if (pick_dm)     state_nxt = GRANT_DM;
                else if (if_vis) state_nxt = GRANT_IF;
            end
            GRANT_IF: begin
                bus.mmu_ren = 1'b1;
                if (finish || expire) state_nxt = IDLE;
            end
            GRANT_DM: begin
                bus.mmu_ren = !wen_q;
                bus.mmu_wen = wen_q;
                if (finish || expire) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            bsel_q     <= '0;
            wen_q      <= 1'b0;
            wd_cnt     <= '0;
            if_done_q  <= 1'b0;
            dm_done_q  <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            timeout_q  <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_dm    <= 1'b0;
`endif
        end else begin
            if_done_q <= 1'b0;
            dm_done_q <= 1'b0;
            if (state == IDLE) begin
                if (pick_dm) begin
                    addr_q  <= bus.dm_addr;
                    wdata_q <= bus.dm_wdata;
                    bsel_q  <= bus.dm_bsel;
                    wen_q   <= bus.dm_wen;
                    wd_cnt  <= '0;
                end else if (if_vis) begin
                    addr_q  <= bus.if_addr;
                    bsel_q  <= 4'b1111;
                    wen_q   <= 1'b0;
                    wd_cnt  <= '0;
                end
            end else if (finish || expire) begin
                if (state == GRANT_IF) begin
                    if_done_q  <= 1'b1;
                    if_rdata_q <= expire ? 32'h0 : bus.mmu_dataout;
                end else begin
                    dm_done_q <= 1'b1;
                    if (expire)      dm_rdata_q <= 32'h0;
                    else if (!wen_q) dm_rdata_q <= bus.mmu_dataout;
                end
                if (expire) timeout_q <= 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                last_dm <= (state == GRANT_DM);
`endif
            end else begin
                wd_cnt <= wd_cnt + 8'd1;
            end
        end
    end

    assign bus.mmu_addy    = addr_q;
    assign bus.mmu_datain  = wdata_q;
    assign bus.mmu_bsel    = bsel_q;
    assign bus.if_done     = if_done_q;
    assign bus.dm_done     = dm_done_q;
    assign bus.if_rdata    = if_rdata_q;
    assign bus.dm_rdata    = dm_rdata_q;
    assign bus.timeout_err = timeout_q;
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: max cycles a grant waits for mmu_nostall before abort (range 2..255).
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-004 if_req  input  1  instruction-fetch read request, level, held until if_done.
REQ-005 if_addr  input  32  fetch address.
REQ-006 if_rdata  output  32  fetch read data, valid when if_done=1.
REQ-007 if_done  output  1  one-cycle completion pulse for fetch port.
REQ-008 dm_req  input  1  data-port request, level, held until dm_done.
REQ-009 dm_wen  input  1  1=write, 0=read for data port.
REQ-010 dm_addr  input  32  data address.
REQ-011 dm_wdata  input  32  write data.
REQ-012 dm_bsel  input  4  byte-select vector.
REQ-013 dm_rdata  output  32  data read result, valid when dm_done=1 and access was a read.
REQ-014 dm_done  output  1  one-cycle completion pulse for data port.
REQ-015 mmu_addy, mmu_datain  output  32 each  address/write data to shared memory management unit.
REQ-016 mmu_ren, mmu_wen  output  1 each  read/write strobes to memory management unit.
REQ-017 mmu_bsel  output  4  byte select to memory management unit.
REQ-018 mmu_dataout  input  32  read data from memory management unit.
REQ-019 mmu_nostall  input  1  1=current access complete this cycle.
REQ-020 timeout_err  output  1  sticky flag, set on any timeout abort.

Function
REQ-021 FSM states IDLE, GRANT_IF, GRANT_DM; one transaction in flight at a time.
REQ-022 IDLE: on posedge with any request, latch winner's addr/wdata/bsel/wen into internal registers and enter its GRANT state; no request -> stay IDLE.
REQ-023 Fixed priority (macro absent): dm_req beats if_req when both high in same cycle.
REQ-024 GRANT_IF: mmu_ren=1, mmu_wen=0, mmu_bsel=4'b1111, mmu_addy=latched if_addr; fetch never writes.
REQ-025 GRANT_DM: mmu_ren=~wen_latched, mmu_wen=wen_latched, addy/datain/bsel from latched values.
REQ-026 IDLE: mmu_ren=mmu_wen=0; mmu_addy/datain/bsel hold last latched values.
REQ-027 Completion: posedge in GRANT_x with mmu_nostall=1 -> capture mmu_dataout into x_rdata (reads only), pulse x_done for exactly the following cycle, return IDLE.
REQ-028 Minimum latency: request visible at edge N -> grant from N, done high N+1..N+2 (2 cycles); back-to-back grants require one IDLE cycle between.
REQ-029 Requester dropping req mid-grant does not abort; transaction completes and done still pulses.
REQ-030 dm write completion leaves dm_rdata unchanged.
REQ-031 Watchdog: 8-bit counter clears on grant entry, increments each GRANT cycle without nostall; reaching TIMEOUT_CYCLES -> abort, x_done pulse, x_rdata=32'h0, timeout_err=1, return IDLE.
REQ-032 nostall and timeout in same cycle: nostall wins, normal completion, no error.
REQ-033 if_done and dm_done never high in same cycle.

Reset
REQ-034 reset=0 asynchronously forces IDLE, all outputs 0, counter 0, timeout_err 0, round-robin pointer = "IF last served".
REQ-035 Reset during a grant aborts silently: no done pulse after release; first post-reset request is arbitrated fresh.

Configuration
REQ-036 Macro MEM_ARB_ROUND_ROBIN_EN defined: 1-bit last-served pointer updated at each completion; on simultaneous requests the port not last served wins.
REQ-037 Macro undefined: pointer absent, fixed DM-over-IF priority per REQ-023.

Verification
REQ-038 Single fetch: if_req=1, if_addr=0x100, nostall at first grant cycle, mmu_dataout=0x00000013 -> mmu_ren=1 addy=0x100, if_done pulse with if_rdata=0x00000013 two cycles after request.
REQ-039 Contention: if_req and dm_req (read 0x2000) both high, no macro -> DM served first, IF next after one IDLE cycle; with macro, two rounds of contention alternate DM, IF, DM, IF.
REQ-040 DM write: dm_wen=1, addr=0x40, wdata=0xCAFEBABE, bsel=4'b0011, nostall after 3 cycles -> mmu_wen=1 with those values, mmu_ren=0, dm_done pulse, dm_rdata unchanged.
REQ-041 Timeout: TIMEOUT_CYCLES=4, nostall held 0 -> after 4 grant cycles dm_done pulses, dm_rdata=0, timeout_err=1 and stays 1 through later good transactions.
REQ-042 Reset mid-grant: assert reset=0 during GRANT_IF -> outputs 0 immediately, no if_done after release, next request completes normally.
